// File: rtl/rf_write_arbiter_if.sv
// Requester-side bundle for rf_write_arbiter: three write requesters
// (0 = ALU, 1 = load, 2 = mul/div) with valid/ready handshakes.
interface rf_write_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [2:0]        req_valid;
  logic [2:0]        req_ready;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [ADDR_W-1:0] req_addr2;
  logic [DATA_W-1:0] req_data0;
  logic [DATA_W-1:0] req_data1;
  logic [DATA_W-1:0] req_data2;

  // Requester side drives requests and observes grants.
  modport master (
    output req_valid, req_addr0, req_addr1, req_addr2,
    output req_data0, req_data1, req_data2,
    input  req_ready
  );

  // Arbiter side observes requests and drives grants.
  modport slave (
    input  req_valid, req_addr0, req_addr1, req_addr2,
    input  req_data0, req_data1, req_data2,
    output req_ready
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: round-robin grant among three
// requesters, one registered RF write per cycle, writes to r0 dropped.
// Optional forwarding of the registered write onto two read ports is
// enabled by defining the macro RF_WRITE_ARB_FWD_EN; otherwise the
// forwarding outputs are tied to zero.
module rf_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  rf_write_arbiter_if.slave  req_if,
  input  logic               hold,
  output logic               RegWrite,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0]  rd_addr1,
  input  logic [ADDR_W-1:0]  rd_addr2,
  output logic               fwd_hit1,
  output logic               fwd_hit2,
  output logic [DATA_W-1:0]  fwd_data1,
  output logic [DATA_W-1:0]  fwd_data2
);

  // Round-robin pointer: the requester index that has highest priority.
  typedef enum logic [1:0] {
    PTR_0 = 2'd0,
    PTR_1 = 2'd1,
    PTR_2 = 2'd2
  } rr_ptr_e;

  rr_ptr_e           ptr_r;
  rr_ptr_e           ptr_nxt_s;
  logic [2:0]        grant_s;
  logic              grant_vld_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              reg_write_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;

  // One-hot grant picking the first valid requester in order p, p+1, p+2 (mod 3).
  function automatic logic [2:0] rr_pick(input logic [2:0] v, input rr_ptr_e p);
    logic [2:0] g;
    g = 3'b000;
    case (p)
      PTR_0: begin
        if (v[0]) g = 3'b001;
        else if (v[1]) g = 3'b010;
        else if (v[2]) g = 3'b100;
        else g = 3'b000;
      end
      PTR_1: begin
        if (v[1]) g = 3'b010;
        else if (v[2]) g = 3'b100;
        else if (v[0]) g = 3'b001;
        else g = 3'b000;
      end
      PTR_2: begin
        if (v[2]) g = 3'b100;
        else if (v[0]) g = 3'b001;
        else if (v[1]) g = 3'b010;
        else g = 3'b000;
      end
      default: g = 3'b000;
    endcase
    return g;
  endfunction

  // Combinational grant; reset and hold both suppress every grant.
  always_comb begin
    grant_s = 3'b000;
    if (rst || hold) begin
      grant_s = 3'b000;
    end else begin
      grant_s = rr_pick(req_if.req_valid, ptr_r);
    end
  end

  assign grant_vld_s      = |grant_s;
  assign req_if.req_ready = grant_s;

  // Select address/data of the granted requester.
  always_comb begin
    sel_addr_s = {ADDR_W{1'b0}};
    sel_data_s = {DATA_W{1'b0}};
    case (grant_s)
      3'b001: begin
        sel_addr_s = req_if.req_addr0;
        sel_data_s = req_if.req_data0;
      end
      3'b010: begin
        sel_addr_s = req_if.req_addr1;
        sel_data_s = req_if.req_data1;
      end
      3'b100: begin
        sel_addr_s = req_if.req_addr2;
        sel_data_s = req_if.req_data2;
      end
      default: begin
        sel_addr_s = {ADDR_W{1'b0}};
        sel_data_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // Next pointer: one past the granted index, unchanged when nothing is granted.
  always_comb begin
    ptr_nxt_s = ptr_r;
    case (grant_s)
      3'b001:  ptr_nxt_s = PTR_1;
      3'b010:  ptr_nxt_s = PTR_2;
      3'b100:  ptr_nxt_s = PTR_0;
      default: ptr_nxt_s = ptr_r;
    endcase
  end

  // Pointer register; reset restarts the rotation at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= PTR_0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // RF write register; a granted write to r0 completes the handshake but is not issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_r <= 1'b0;
      wr_addr_r   <= {ADDR_W{1'b0}};
      wr_data_r   <= {DATA_W{1'b0}};
    end else if (grant_vld_s) begin
      reg_write_r <= (sel_addr_s != {ADDR_W{1'b0}});
      wr_addr_r   <= sel_addr_s;
      wr_data_r   <= sel_data_s;
    end else begin
      reg_write_r <= 1'b0;
      wr_addr_r   <= wr_addr_r;
      wr_data_r   <= wr_data_r;
    end
  end

  assign RegWrite = reg_write_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;

`ifdef RF_WRITE_ARB_FWD_EN
  // Bypass the write being issued this cycle to matching read ports (r0 never matches).
  assign fwd_hit1  = reg_write_r && (wr_addr_r == rd_addr1) && (rd_addr1 != {ADDR_W{1'b0}});
  assign fwd_hit2  = reg_write_r && (wr_addr_r == rd_addr2) && (rd_addr2 != {ADDR_W{1'b0}});
  assign fwd_data1 = wr_data_r;
  assign fwd_data2 = wr_data_r;
`else
  logic unused_rd_s;
  assign unused_rd_s = ^{rd_addr1, rd_addr2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = {DATA_W{1'b0}};
  assign fwd_data2 = {DATA_W{1'b0}};
`endif

endmodule
